// File: rtl/serial_adder_fsm_if.sv
// Bus bundle for serial_adder_fsm: operand/control inputs and result outputs.
// Macro SERIAL_ADDER_SUB_MODE_EN adds the sub control signal.
interface serial_adder_fsm_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_MODE_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  // Requester side: drives operands and control, observes the result.
  modport master (
`ifdef SERIAL_ADDER_SUB_MODE_EN
    output sub,
`endif
    output start, rst, a, b, cin,
    input  sum, cout, ovf, busy, done
  );

  // Adder side.
  modport slave (
`ifdef SERIAL_ADDER_SUB_MODE_EN
    input  sub,
`endif
    input  start, rst, a, b, cin,
    output sum, cout, ovf, busy, done
  );
endinterface

// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: one operand bit per cycle, LSB first, result shifted in
// at the MSB of sum. Macro SERIAL_ADDER_SUB_MODE_EN adds a subtract mode
// (a - b computed as a + ~b + 1, cout=1 meaning no borrow).
module serial_adder_fsm #(
  parameter int unsigned WIDTH = 8
) (
  input logic              CLK,
  input logic              NRST,
  serial_adder_fsm_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic             accept_c;
  logic             last_c;
  logic             bit_s_c;
  logic             bit_c_c;
  logic [WIDTH-1:0] b_eff_c;
  logic             cin_eff_c;

  // Operand/carry selection at capture time (invert b and force carry for subtract).
`ifdef SERIAL_ADDER_SUB_MODE_EN
  assign b_eff_c   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff_c = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_eff_c   = bus.b;
  assign cin_eff_c = bus.cin;
`endif

  // Full-adder slice on the current LSBs of the shifting operand registers.
  assign bit_s_c = a_q[0] ^ b_q[0] ^ c_q;
  assign bit_c_c = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

  // Next-state logic; synchronous rst overrides everything, including start.
  always_comb begin
    state_d  = state;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.rst && bus.start) begin
          state_d  = ADD;
          accept_c = 1'b1;
        end
      end
      ADD: begin
        last_c = (cnt == LAST);
        if (bus.rst) begin
          state_d = IDLE;
        end else if (last_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register plus registered busy/done decoded from the next state.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      busy_q <= (state_d == ADD);
      done_q <= (state_d == DONE);
    end
  end

  // Datapath: capture, per-bit add/shift, final carry/overflow latch.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (bus.rst) begin
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept_c) begin
      a_q   <= bus.a;
      b_q   <= b_eff_c;
      c_q   <= cin_eff_c;
      cnt   <= '0;
      sum_q <= '0;
    end else if (state == ADD) begin
      sum_q <= {bit_s_c, sum_q[WIDTH-1:1]};
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      c_q   <= bit_c_c;
      if (last_c) begin
        cout_q <= bit_c_c;
        ovf_q  <= bit_c_c ^ c_q;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Self-checking bench for serial_adder_fsm (WIDTH=8).
module tb_serial_adder_fsm;

  localparam int unsigned WIDTH = 8;

  logic CLK  = 1'b0;
  logic NRST = 1'b0;

  always #5 CLK = ~CLK;

  serial_adder_fsm_if #(.WIDTH(WIDTH)) bus ();

  serial_adder_fsm #(.WIDTH(WIDTH)) dut (
    .CLK  (CLK),
    .NRST (NRST),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Arithmetic reference: returns {ovf, cout, sum}.
  function automatic logic [WIDTH+1:0] golden(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic ci);
    logic [WIDTH:0] full;
    logic           v;
    full = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
    v    = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    return {v, full};
  endfunction

  // Transaction-level model: remaining add cycles and the pending/held result.
  int               rem    = 0;
  logic             m_done = 1'b0;
  logic [WIDTH-1:0] m_sum  = '0;
  logic             m_cout = 1'b0;
  logic             m_ovf  = 1'b0;
  logic [WIDTH+1:0] p_res  = '0;

  always @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      rem    <= 0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_ovf  <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (bus.rst) begin
        rem    <= 0;
        m_sum  <= '0;
        m_cout <= 1'b0;
        m_ovf  <= 1'b0;
      end else if (rem > 0) begin
        rem <= rem - 1;
        if (rem == 1) begin
          m_done <= 1'b1;
          m_sum  <= p_res[WIDTH-1:0];
          m_cout <= p_res[WIDTH];
          m_ovf  <= p_res[WIDTH+1];
        end
      end else if (!m_done && bus.start) begin
        rem   <= WIDTH;
        m_sum <= '0;
`ifdef SERIAL_ADDER_SUB_MODE_EN
        p_res <= golden(bus.a, bus.sub ? ~bus.b : bus.b, bus.sub ? 1'b1 : bus.cin);
`else
        p_res <= golden(bus.a, bus.b, bus.cin);
`endif
      end
    end
  end

  // Cycle compare against the model; sum/cout/ovf only when not mid-add.
  always @(negedge CLK) begin
    if (NRST) begin
      check("model_busy", 64'(bus.busy), 64'(rem > 0));
      check("model_done", 64'(bus.done), 64'(m_done));
      if (rem == 0) begin
        check("model_sum", 64'(bus.sum), 64'(m_sum));
        check("model_cout", 64'(bus.cout), 64'(m_cout));
        check("model_ovf", 64'(bus.ovf), 64'(m_ovf));
      end
    end
  end

  task automatic wait_done(output int busy_cycles, output bit seen);
    busy_cycles = 0;
    seen        = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_cycles++;
      @(negedge CLK);
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ci,
                        input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                        input string nm);
    int bc;
    bit seen;
    @(negedge CLK);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = ci;
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    wait_done(bc, seen);
    check({nm, "_done_seen"}, 64'(seen), 64'd1);
    check({nm, "_busy_cycles"}, 64'(bc), 64'(WIDTH));
    check({nm, "_sum"}, 64'(bus.sum), 64'(es));
    check({nm, "_cout"}, 64'(bus.cout), 64'(ec));
    check({nm, "_ovf"}, 64'(bus.ovf), 64'(eo));
  endtask

  task automatic expect_no_done(input string nm);
    bit seen;
    seen = 1'b0;
    repeat (12) begin
      @(negedge CLK);
      if (bus.done) seen = 1'b1;
    end
    check(nm, 64'(seen), 64'd0);
  endtask

  initial begin
    int  bc;
    bit  seen;
    bus.start = 1'b0;
    bus.rst   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_MODE_EN
    bus.sub   = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    check("reset_sum", 64'(bus.sum), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_cout_ovf", 64'({bus.cout, bus.ovf}), 64'd0);
    NRST = 1'b1;

    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01");
    run_op(8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, "add_ff_01_c1");
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
    run_op(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, "add_aa_55_c1");

    // Synchronous rst on the third ADD cycle.
    @(negedge CLK);
    bus.a = 8'h0F; bus.b = 8'h30; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    bus.rst = 1'b1;
    @(negedge CLK);
    bus.rst = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    expect_no_done("rst_no_done");
    run_op(8'h0F, 8'h30, 1'b0, 8'h3F, 1'b0, 1'b0, "after_rst");

    // start re-asserted during ADD with new operands, then during DONE.
    @(negedge CLK);
    bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    @(negedge CLK);
    bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1; bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    wait_done(bc, seen);
    check("restart_done_seen", 64'(seen), 64'd1);
    check("restart_sum", 64'(bus.sum), 64'h46);
    check("restart_cout_ovf", 64'({bus.cout, bus.ovf}), 64'd0);
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    check("start_in_done_ignored", 64'(bus.busy), 64'd0);

    // start and rst together in IDLE.
    @(negedge CLK);
    bus.start = 1'b1; bus.rst = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0; bus.rst = 1'b0;
    check("start_rst_idle_busy", 64'(bus.busy), 64'd0);
    check("start_rst_idle_sum", 64'(bus.sum), 64'd0);

    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "add_80_80");

    // NRST pulse mid-ADD.
    @(negedge CLK);
    bus.a = 8'h55; bus.b = 8'h0A; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    repeat (3) @(negedge CLK);
    #2 NRST = 1'b0;
    #1;
    check("nrst_sum", 64'(bus.sum), 64'd0);
    check("nrst_busy", 64'(bus.busy), 64'd0);
    check("nrst_done", 64'(bus.done), 64'd0);
    check("nrst_cout_ovf", 64'({bus.cout, bus.ovf}), 64'd0);
    @(negedge CLK);
    NRST = 1'b1;
    expect_no_done("nrst_no_done");
    run_op(8'h55, 8'h0A, 1'b0, 8'h5F, 1'b0, 1'b0, "after_nrst");

`ifdef SERIAL_ADDER_SUB_MODE_EN
    bus.sub = 1'b1;
    run_op(8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, "sub_05_07");
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, "sub_80_01");
    bus.sub = 1'b0;
`endif

    repeat (2) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
